// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer presenting a framed valid/ready stream
// Optional statistics outputs (pkt_count, stall_count) are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_rd,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           stall_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   issue_cnt_q;
    logic [CNT_WIDTH-1:0]   issue_cnt_d;
    logic                   inflight_q;
    logic                   inflight_last_q;
    logic [1:0]             buf_cnt_q;
    logic [DATA_WIDTH-1:0]  buf_data_q [2];
    logic                   buf_last_q [2];

    logic                   xfer;
    logic                   issue_last;
    logic [2:0]             occ;

    assign xfer       = m_valid && m_ready;
    assign issue_last = (issue_cnt_q == LAST_IDX);
    assign occ        = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    assign issue_cnt_d = issue_last ? '0 : issue_cnt_q + 1'b1;

    // Pop whenever reading is allowed and the word will have a buffer slot when it lands.
    always_comb begin
        fifo_rd = (state_q == RUN || state_q == STOP) && !fifo_empty
                  && (occ < 3'd2 || xfer);
    end

    // Stream outputs come straight from the buffer head register.
    always_comb begin
        m_valid = (buf_cnt_q != 2'd0);
        m_data  = buf_data_q[0];
        m_last  = buf_last_q[0];
        busy    = (state_q != IDLE) || inflight_q || (buf_cnt_q != 2'd0);
    end

    // Control FSM: stopping mid-packet keeps popping until the packet's last word is issued.
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (en) state_q <= RUN;
                RUN: begin
                    if (!en) begin
                        if (issue_cnt_q == '0 || (fifo_rd && issue_last)) state_q <= IDLE;
                        else                                              state_q <= STOP;
                    end
                end
                STOP: if (fifo_rd && issue_last) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Issue counter and in-flight tracker; the last flag is fixed at pop time.
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (fifo_rd) issue_cnt_q <= issue_cnt_d;
            inflight_q      <= fifo_rd;
            inflight_last_q <= fifo_rd && issue_last;
        end
    end

    // Two-entry skid buffer; entry 0 is always the head, pops shift entry 1 down.
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            buf_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            case ({inflight_q, xfer})
                2'b10: begin
                    buf_data_q[buf_cnt_q[0]] <= fifo_data;
                    buf_last_q[buf_cnt_q[0]] <= inflight_last_q;
                    buf_cnt_q                <= buf_cnt_q + 2'd1;
                end
                2'b01: begin
                    buf_data_q[0] <= buf_data_q[1];
                    buf_last_q[0] <= buf_last_q[1];
                    buf_cnt_q     <= buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf_data_q[0] <= fifo_data;
                        buf_last_q[0] <= inflight_last_q;
                    end else begin
                        buf_data_q[0] <= buf_data_q[1];
                        buf_last_q[0] <= buf_last_q[1];
                        buf_data_q[1] <= fifo_data;
                        buf_last_q[1] <= inflight_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Packet counter wraps; stall counter saturates.
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (xfer && m_last) pkt_count <= pkt_count + 32'd1;
            if (m_valid && !m_ready && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
